// File: rtl/io_bridge_burst_peripheral.sv
// Serial 2-lane host link to parallel PMP bus bridge with burst read/write.
// Everything runs on clk; the host clock and select are oversampled through synchronisers.
`timescale 1ns/1ps
module io_bridge_burst_peripheral #(
  parameter int ADDR_BYTES  = 4,
  parameter int DATA_BYTES  = 4,
  parameter int LANES       = 2,
  parameter int READ_DELAY  = 4,
  parameter int WORD_GAP    = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    endian_little,
  output logic [8*ADDR_BYTES-1:0] pmp_addr,
  output logic                    pmp_addr_valid,
  output logic                    pmp_rd,
  input  logic [8*DATA_BYTES-1:0] pmp_rd_data,
  output logic                    pmp_wr,
  output logic [8*DATA_BYTES-1:0] pmp_wr_data,
  inout  wire                     phy_spimosi,
  inout  wire                     phy_spimiso,
  inout  wire                     phy_spiclk,
  input  logic                    phy_spiss,
  output logic [15:0]             burst_words
);
  // state      | meaning
  // ST_HDR     | collecting address header bytes
  // ST_WR      | collecting write data bytes
  // ST_RD_WAIT | waiting for read data (initial delay or inter-word gap)
  // ST_TX_PRE  | clock and lanes driven high before the first symbol
  // ST_TX_LO   | clock low, symbol on lanes
  // ST_TX_HI   | clock high, symbol held
  // ST_TX_POST | lanes high one cycle before release
  // ST_DONE    | transaction finished, wait for deselect
  localparam int AW      = 8*ADDR_BYTES;
  localparam int DW      = 8*DATA_BYTES;
  localparam int SYMS    = DW/LANES;
  localparam int RX_LAST = 8/LANES - 1;
  localparam int GAP     = (WORD_GAP > READ_DELAY) ? WORD_GAP : READ_DELAY;

  typedef enum logic [2:0] {
    ST_HDR, ST_WR, ST_RD_WAIT, ST_TX_PRE, ST_TX_LO, ST_TX_HI, ST_TX_POST, ST_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_ss_sync, r_end_sync, r_mosi_sync, r_miso_sync;
  logic             r_clk_prev;
  logic [7:0]       r_rx_byte;
  logic [2:0]       r_rx_cnt;
  logic             r_byte_vld;
  logic [AW-9:0]    r_hdr;
  logic [7:0]       r_byte_cnt;
  logic [AW-1:0]    r_addr;
  logic             r_addr_valid, r_burst, r_wr, r_rd;
  logic [DW-1:0]    r_wr_latch, r_tx_buf;
  logic [15:0]      r_cnt, r_words;
  logic [7:0]       r_sym_cnt;
  logic             r_oe, r_tx_clk, r_tx_mosi, r_tx_miso;

  logic             w_clk_s, w_abort, w_end_s, w_clk_rise, w_rx_en, w_hdr_last, w_data_last;
  logic [LANES-1:0] w_lanes, w_sym;
  logic [AW-1:0]    w_hdr_shift;
  logic [DW-1:0]    w_data_shift;

  function automatic logic [DW-1:0] f_swap(input logic [DW-1:0] d);
    logic [DW-1:0] o;
    for (int i = 0; i < DATA_BYTES; i++) o[8*i +: 8] = d[DW-8-8*i +: 8];
    return o;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_ss_sync   <= '1;
      r_end_sync  <= '0;
      r_mosi_sync <= '0;
      r_miso_sync <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], phy_spiclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], phy_spiss};
      r_end_sync  <= {r_end_sync[SYNC_STAGES-2:0], endian_little};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], phy_spimosi};
      r_miso_sync <= {r_miso_sync[SYNC_STAGES-2:0], phy_spimiso};
    end
  end

  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_abort      = r_ss_sync[SYNC_STAGES-1];
  assign w_end_s      = r_end_sync[SYNC_STAGES-1];
  assign w_clk_rise   = w_clk_s & ~r_clk_prev;
  assign w_rx_en      = ((r_state == ST_HDR) || (r_state == ST_WR)) && !w_abort;
  assign w_lanes      = (LANES == 2) ? LANES'({r_mosi_sync[SYNC_STAGES-1], r_miso_sync[SYNC_STAGES-1]})
                                     : LANES'(r_mosi_sync[SYNC_STAGES-1]);
  assign w_sym        = r_tx_buf[DW-1 -: LANES];
  assign w_hdr_shift  = {r_hdr, r_rx_byte};
  assign w_data_shift = {r_wr_latch[DW-9:0], r_rx_byte};

  // Lanes are synchronised with the clock so the sampled data lines up with the detected edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_prev <= 1'b1;
      r_rx_byte  <= '0;
      r_rx_cnt   <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_clk_prev <= w_clk_s;
      r_byte_vld <= 1'b0;
      if (!w_rx_en) begin
        r_rx_cnt <= '0;
      end else if (w_clk_rise) begin
        r_rx_byte  <= {r_rx_byte[7-LANES:0], w_lanes};
        r_byte_vld <= (r_rx_cnt == 3'(RX_LAST));
        r_rx_cnt   <= (r_rx_cnt == 3'(RX_LAST)) ? 3'd0 : r_rx_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_HDR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_last  = r_byte_vld && (r_state == ST_HDR) && (r_byte_cnt == 8'(ADDR_BYTES-1));
    w_data_last = r_byte_vld && (r_state == ST_WR) && (r_byte_cnt == 8'(DATA_BYTES-1));
    case (r_state)
      ST_HDR:     if (w_hdr_last) w_state_nxt = r_rx_byte[0] ? ST_WR : ST_RD_WAIT;
      ST_WR:      if (w_data_last && !r_burst) w_state_nxt = ST_DONE;
      ST_RD_WAIT: if (r_cnt == 16'd0) w_state_nxt = ST_TX_PRE;
      ST_TX_PRE:  w_state_nxt = ST_TX_LO;
      ST_TX_LO:   w_state_nxt = ST_TX_HI;
      ST_TX_HI:   w_state_nxt = (r_sym_cnt == 8'd0) ? ST_TX_POST : ST_TX_LO;
      ST_TX_POST: w_state_nxt = r_burst ? ST_RD_WAIT : ST_DONE;
      default:    w_state_nxt = r_state;
    endcase
    if (w_abort) w_state_nxt = ST_HDR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hdr <= '0; r_byte_cnt <= '0; r_addr <= '0; r_addr_valid <= 1'b0; r_burst <= 1'b0;
      r_wr_latch <= '0; r_wr <= 1'b0; r_rd <= 1'b0; r_cnt <= '0; r_words <= '0;
      r_tx_buf <= '0; r_sym_cnt <= '0; r_oe <= 1'b0; r_tx_clk <= 1'b1;
      r_tx_mosi <= 1'b1; r_tx_miso <= 1'b1;
    end else begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (w_abort) begin
        r_hdr <= '0; r_byte_cnt <= '0; r_addr <= '0; r_addr_valid <= 1'b0; r_burst <= 1'b0;
        r_wr_latch <= '0; r_cnt <= '0; r_words <= '0; r_tx_buf <= '0; r_sym_cnt <= '0;
        r_oe <= 1'b0; r_tx_clk <= 1'b1; r_tx_mosi <= 1'b1; r_tx_miso <= 1'b1;
      end else begin
        if (r_byte_vld && (r_state == ST_HDR)) begin
          if (w_hdr_last) begin
            r_hdr        <= '0;
            r_byte_cnt   <= '0;
            r_addr       <= w_hdr_shift & ~AW'(DATA_BYTES-1);
            r_addr_valid <= 1'b1;
            r_burst      <= r_rx_byte[1];
            r_cnt        <= 16'(READ_DELAY);
          end else begin
            r_hdr      <= w_hdr_shift[AW-9:0];
            r_byte_cnt <= r_byte_cnt + 8'd1;
          end
        end
        if (r_byte_vld && (r_state == ST_WR)) begin
          r_wr_latch <= w_data_shift;
          if (w_data_last) begin
            r_byte_cnt <= '0;
            r_wr       <= 1'b1;
            r_words    <= (r_words == 16'hFFFF) ? r_words : r_words + 16'd1;
          end else begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
          end
        end
        if (r_wr && r_burst) r_addr <= r_addr + AW'(DATA_BYTES);
        case (r_state)
          ST_RD_WAIT: begin
            if (r_cnt == 16'd0) begin
              r_tx_buf  <= w_end_s ? f_swap(pmp_rd_data) : pmp_rd_data;
              r_rd      <= 1'b1;
              r_oe      <= 1'b1;
              r_tx_clk  <= 1'b1;
              r_tx_mosi <= 1'b1;
              r_tx_miso <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          ST_TX_PRE: begin
            r_tx_clk  <= 1'b0;
            r_tx_mosi <= w_sym[LANES-1];
            r_tx_miso <= w_sym[0];
            r_tx_buf  <= {r_tx_buf[DW-LANES-1:0], {LANES{1'b0}}};
            r_sym_cnt <= 8'(SYMS-1);
          end
          ST_TX_LO: r_tx_clk <= 1'b1;
          ST_TX_HI: begin
            if (r_sym_cnt == 8'd0) begin
              r_tx_mosi <= 1'b1;
              r_tx_miso <= 1'b1;
            end else begin
              r_tx_clk  <= 1'b0;
              r_tx_mosi <= w_sym[LANES-1];
              r_tx_miso <= w_sym[0];
              r_tx_buf  <= {r_tx_buf[DW-LANES-1:0], {LANES{1'b0}}};
              r_sym_cnt <= r_sym_cnt - 8'd1;
            end
          end
          ST_TX_POST: begin
            r_oe    <= 1'b0;
            r_words <= (r_words == 16'hFFFF) ? r_words : r_words + 16'd1;
            if (r_burst) begin
              r_addr <= r_addr + AW'(DATA_BYTES);
              r_cnt  <= 16'(GAP);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pmp_addr       = r_addr;
  assign pmp_addr_valid = r_addr_valid;
  assign pmp_rd         = r_rd;
  assign pmp_wr         = r_wr;
  assign pmp_wr_data    = w_end_s ? f_swap(r_wr_latch) : r_wr_latch;
  assign burst_words    = r_words;
  assign phy_spimosi    = r_oe ? r_tx_mosi : 1'bz;
  assign phy_spimiso    = (r_oe && (LANES == 2)) ? r_tx_miso : 1'bz;
  assign phy_spiclk     = r_oe ? r_tx_clk : 1'bz;
endmodule
